decode_stage: RTL and testbench
===============================

# decode_stage

Registered, parametrised RV32I decode stage between fetch and execute. Accepts a fetched instruction word plus its PC over a valid/ready handshake and decodes the full RV32I base set, including LUI, AUIPC, FENCE, ECALL and EBREAK. Immediates are sign-extended to XLEN. Results are presented through an output register backed by a one-entry skid buffer, so fetch never stalls on a combinational ready path. Supports pipeline flush on branch/jump redirect.

## Interface
Parameters:
- XLEN, 32, datapath width; immediates sign-extended to XLEN (legal values 32, 64).
- PC_W, 32, PC width carried through.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- flush_i  in  1  drop all held and incoming instructions.
- in_valid_i  in  1  instr_i/pc_i valid.
- in_ready_o  out  1  stage can accept.
- instr_i  in  32  instruction word.
- pc_i  in  PC_W  instruction PC.
- out_valid_o  out  1  decoded bundle valid.
- out_ready_i  in  1  execute accepts the bundle.
- pc_o  out  PC_W  PC of the decoded instruction.
- alu_op_o  out  4  ALU/compare operation.
- rs1_o, rs2_o, rd_o  out  5 each  register indices.
- funct3_o  out  3  instr[14:12].
- imm_o  out  XLEN  sign-extended immediate.
- reg_write_o, use_imm_o, branch_o, jump_o, jalr_o, mem_read_o, mem_write_o, mem_to_reg_o, lui_o, auipc_o, system_o  out  1 each  control flags.
- illegal_o  out  1  undecodable instruction.

## Operation
- ALU encoding: ADD 0000, SLT 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SUB 0111, SRA 1000, SLTU 1001.
- Branch compare encoding, with branch_o=1: BEQ 0001, BNE 0010, BLT 0011, BGE 0100, BLTU 0101, BGEU 0110.
- OP-IMM: funct3=101 with instr[30]=1 selects SRA (SRAI), else SRL.
- OP: instr[30] selects SUB/SRA.
- Immediate formats, each sign-extended from instr[31] to XLEN:
  - I: OP-IMM, LOAD, JALR.
  - S: STORE.
  - B: BRANCH, bit0 = 0.
  - J: JAL, bit0 = 0.
  - U: LUI/AUIPC, instr[31:12]<<12.
- Per-opcode controls:
  - JAL: jump_o=1, reg_write_o=1, use_imm_o=1.
  - JALR: jump_o=1, jalr_o=1, reg_write_o=1, use_imm_o=1, alu_op ADD.
  - LOAD/STORE: alu_op ADD, use_imm_o=1.
  - LUI/AUIPC: reg_write_o=1, use_imm_o=1.
  - FENCE: decodes as NOP (all flags 0).
  - SYSTEM (1110011, funct3=000): system_o=1.
- Unused control fields are 0, alu_op 0000.
- Storage: output register (R) plus skid entry (S).
  - in_ready_o = !S_full (registered).
  - On accept: if R empty or draining (out_valid_o & out_ready_i), the decode result loads R; otherwise it loads S.
  - When R drains and S is full, S moves to R and S empties.
- flush_i: clears R and S valid on the next edge. Input presented in the flush cycle is discarded. Flush wins over every simultaneous accept or drain.
- Decoding happens before storage; S holds the decoded bundle.

## Timing
- Latency 1 cycle: an instruction accepted at edge N appears on out_valid_o after edge N.
- Throughput 1 instruction per cycle with out_ready_i held high.
- in_ready_o falls one cycle after a stall, once S fills. At most 2 instructions are held.
- Reset values: out_valid_o=0, in_ready_o=1, all decoded outputs 0, pc_o=0.
- Reset asserted mid-operation discards R and S immediately.
- The bundle stays stable while out_valid_o=1 and out_ready_i=0.

## Configuration
- DECODE_ILLEGAL_EN defined: illegal_o=1, with all write/mem/branch/jump flags forced 0, for:
  - unknown opcode;
  - instr[1:0]!=11;
  - bad funct7 on OP;
  - bad funct7 on SLLI/SRLI/SRAI;
  - undefined branch funct3;
  - undefined load/store funct3.
- Not defined: illegal_o tied 0; unknown encodings decode as NOP.

## Test plan
- ADDI x1,x0,-1 (0xFFF00093), out_ready high -> one cycle later: alu_op 0000, rd=1, imm_o=0xFFFFFFFF, reg_write_o=1, use_imm_o=1.
- SRAI x2,x2,3 (0x40315113) -> alu_op 1000. SUB (0x40208033) -> 0111.
- BEQ offset -4 (0xFE000EE3) -> branch_o=1, alu_op 0001, imm_o=0xFFFFFFFC. JALR (0x000080E7) -> jalr_o=1, imm_o=0.
- Stream 3 instructions with out_ready_i=0 -> first in R, second in S, in_ready_o=0. Raise out_ready_i -> all three emerge in order, none lost or duplicated.
- Hold R and S full, assert flush_i with in_valid_i=1 -> next cycle out_valid_o=0, in_ready_o=1; the flushed instructions never appear.
- With DECODE_ILLEGAL_EN: 0x00000000 -> illegal_o=1, reg_write_o=0. Without it: illegal_o=0 and NOP flags.

Source files
------------

// File: rtl/decode_stage_if.sv
// Fetch-to-execute handshake and decoded-bundle signals for decode_stage.
// slave is the decode stage side, master is the fetch/execute side.
interface decode_stage_if #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
);
  logic            flush_i;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [31:0]     instr_i;
  logic [PC_W-1:0] pc_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [PC_W-1:0] pc_o;
  logic [3:0]      alu_op_o;
  logic [4:0]      rs1_o;
  logic [4:0]      rs2_o;
  logic [4:0]      rd_o;
  logic [2:0]      funct3_o;
  logic [XLEN-1:0] imm_o;
  logic            reg_write_o;
  logic            use_imm_o;
  logic            branch_o;
  logic            jump_o;
  logic            jalr_o;
  logic            mem_read_o;
  logic            mem_write_o;
  logic            mem_to_reg_o;
  logic            lui_o;
  logic            auipc_o;
  logic            system_o;
  logic            illegal_o;

  modport slave (
    input  flush_i, in_valid_i, instr_i, pc_i, out_ready_i,
    output in_ready_o, out_valid_o, pc_o, alu_op_o, rs1_o, rs2_o, rd_o,
           funct3_o, imm_o, reg_write_o, use_imm_o, branch_o, jump_o,
           jalr_o, mem_read_o, mem_write_o, mem_to_reg_o, lui_o, auipc_o,
           system_o, illegal_o
  );

  modport master (
    output flush_i, in_valid_i, instr_i, pc_i, out_ready_i,
    input  in_ready_o, out_valid_o, pc_o, alu_op_o, rs1_o, rs2_o, rd_o,
           funct3_o, imm_o, reg_write_o, use_imm_o, branch_o, jump_o,
           jalr_o, mem_read_o, mem_write_o, mem_to_reg_o, lui_o, auipc_o,
           system_o, illegal_o
  );
endinterface

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: output register plus one-entry skid buffer.
// Define DECODE_ILLEGAL_EN to flag undecodable encodings on illegal_o.
module decode_stage #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  decode_stage_if.slave bus
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLT  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SUB  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [3:0]      alu_op;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm;
    logic            reg_write;
    logic            use_imm;
    logic            branch;
    logic            jump;
    logic            jalr;
    logic            mem_read;
    logic            mem_write;
    logic            mem_to_reg;
    logic            lui;
    logic            auipc;
    logic            system;
    logic            illegal;
  } bundle_t;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    sext32 = {{(XLEN-31){v[31]}}, v[30:0]};
  endfunction

  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_of = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_of = ALU_SLL;
      3'b010:  alu_of = ALU_SLT;
      3'b011:  alu_of = ALU_SLTU;
      3'b100:  alu_of = ALU_XOR;
      3'b101:  alu_of = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_of = ALU_OR;
      3'b111:  alu_of = ALU_AND;
      default: alu_of = ALU_ADD;
    endcase
  endfunction

  logic [31:0] ins_s;
  logic [6:0]  opc_s;
  logic [2:0]  f3_s;
  logic [6:0]  f7_s;
  logic [31:0] imm_i_s;
  logic [31:0] imm_st_s;
  logic [31:0] imm_b_s;
  logic [31:0] imm_j_s;
  logic [31:0] imm_u_s;

  assign ins_s    = bus.instr_i;
  assign opc_s    = ins_s[6:0];
  assign f3_s     = ins_s[14:12];
  assign f7_s     = ins_s[31:25];
  assign imm_i_s  = {{20{ins_s[31]}}, ins_s[31:20]};
  assign imm_st_s = {{20{ins_s[31]}}, ins_s[31:25], ins_s[11:7]};
  assign imm_b_s  = {{19{ins_s[31]}}, ins_s[31], ins_s[7], ins_s[30:25], ins_s[11:8], 1'b0};
  assign imm_j_s  = {{11{ins_s[31]}}, ins_s[31], ins_s[19:12], ins_s[20], ins_s[30:21], 1'b0};
  assign imm_u_s  = {ins_s[31:12], 12'h000};

  bundle_t raw_s;
  bundle_t dec_s;
  logic    bad_s;

  // Raw per-opcode decode, with a flag for encodings outside RV32I
  always_comb begin
    raw_s        = '0;
    bad_s        = 1'b0;
    raw_s.pc     = bus.pc_i;
    raw_s.funct3 = f3_s;
    case (opc_s)
      OPC_LUI, OPC_AUIPC: begin
        raw_s.rd        = ins_s[11:7];
        raw_s.imm       = sext32(imm_u_s);
        raw_s.reg_write = 1'b1;
        raw_s.use_imm   = 1'b1;
        raw_s.lui       = (opc_s == OPC_LUI);
        raw_s.auipc     = (opc_s == OPC_AUIPC);
      end
      OPC_JAL: begin
        raw_s.rd        = ins_s[11:7];
        raw_s.imm       = sext32(imm_j_s);
        raw_s.reg_write = 1'b1;
        raw_s.use_imm   = 1'b1;
        raw_s.jump      = 1'b1;
      end
      OPC_JALR: begin
        raw_s.rd        = ins_s[11:7];
        raw_s.rs1       = ins_s[19:15];
        raw_s.imm       = sext32(imm_i_s);
        raw_s.alu_op    = ALU_ADD;
        raw_s.reg_write = 1'b1;
        raw_s.use_imm   = 1'b1;
        raw_s.jump      = 1'b1;
        raw_s.jalr      = 1'b1;
      end
      OPC_BRANCH: begin
        raw_s.rs1    = ins_s[19:15];
        raw_s.rs2    = ins_s[24:20];
        raw_s.imm    = sext32(imm_b_s);
        raw_s.branch = 1'b1;
        case (f3_s)
          3'b000:  raw_s.alu_op = 4'b0001;
          3'b001:  raw_s.alu_op = 4'b0010;
          3'b100:  raw_s.alu_op = 4'b0011;
          3'b101:  raw_s.alu_op = 4'b0100;
          3'b110:  raw_s.alu_op = 4'b0101;
          3'b111:  raw_s.alu_op = 4'b0110;
          default: bad_s = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        raw_s.rd         = ins_s[11:7];
        raw_s.rs1        = ins_s[19:15];
        raw_s.imm        = sext32(imm_i_s);
        raw_s.alu_op     = ALU_ADD;
        raw_s.use_imm    = 1'b1;
        raw_s.reg_write  = 1'b1;
        raw_s.mem_read   = 1'b1;
        raw_s.mem_to_reg = 1'b1;
        case (f3_s)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: bad_s = 1'b0;
          default:                                bad_s = 1'b1;
        endcase
      end
      OPC_STORE: begin
        raw_s.rs1       = ins_s[19:15];
        raw_s.rs2       = ins_s[24:20];
        raw_s.imm       = sext32(imm_st_s);
        raw_s.alu_op    = ALU_ADD;
        raw_s.use_imm   = 1'b1;
        raw_s.mem_write = 1'b1;
        case (f3_s)
          3'b000, 3'b001, 3'b010: bad_s = 1'b0;
          default:                bad_s = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        raw_s.rd        = ins_s[11:7];
        raw_s.rs1       = ins_s[19:15];
        raw_s.imm       = sext32(imm_i_s);
        raw_s.use_imm   = 1'b1;
        raw_s.reg_write = 1'b1;
        // instr[30] is immediate data except on the right-shift form
        raw_s.alu_op    = alu_of(f3_s, ins_s[30] & (f3_s == 3'b101));
        if (f3_s == 3'b001) begin
          bad_s = (f7_s != F7_BASE);
        end else if (f3_s == 3'b101) begin
          bad_s = (f7_s != F7_BASE) && (f7_s != F7_ALT);
        end else begin
          bad_s = 1'b0;
        end
      end
      OPC_OP: begin
        raw_s.rd        = ins_s[11:7];
        raw_s.rs1       = ins_s[19:15];
        raw_s.rs2       = ins_s[24:20];
        raw_s.reg_write = 1'b1;
        raw_s.alu_op    = alu_of(f3_s, ins_s[30]);
        bad_s = !((f7_s == F7_BASE) ||
                  ((f7_s == F7_ALT) && ((f3_s == 3'b000) || (f3_s == 3'b101))));
      end
      OPC_FENCE: begin
        bad_s = 1'b0;
      end
      OPC_SYSTEM: begin
        raw_s.system = (f3_s == 3'b000);
      end
      default: begin
        bad_s = 1'b1;
      end
    endcase
  end

  // Undecodable encodings lose all side effects; illegal_o only with the option
  always_comb begin
    dec_s = raw_s;
    if (bad_s) begin
      dec_s.alu_op     = 4'b0000;
      dec_s.reg_write  = 1'b0;
      dec_s.use_imm    = 1'b0;
      dec_s.branch     = 1'b0;
      dec_s.jump       = 1'b0;
      dec_s.jalr       = 1'b0;
      dec_s.mem_read   = 1'b0;
      dec_s.mem_write  = 1'b0;
      dec_s.mem_to_reg = 1'b0;
      dec_s.lui        = 1'b0;
      dec_s.auipc      = 1'b0;
      dec_s.system     = 1'b0;
    end else begin
      dec_s.alu_op = raw_s.alu_op;
    end
`ifdef DECODE_ILLEGAL_EN
    dec_s.illegal = bad_s;
`else
    dec_s.illegal = 1'b0;
`endif
  end

  bundle_t r_q, r_d;
  bundle_t s_q, s_d;
  logic    r_valid_q, r_valid_d;
  logic    s_valid_q, s_valid_d;
  logic    accept_s;
  logic    drain_s;

  assign accept_s = bus.in_valid_i & ~s_valid_q;
  assign drain_s  = r_valid_q & bus.out_ready_i;

  // Next state of output register and skid entry; flush overrides everything
  always_comb begin
    r_d       = r_q;
    s_d       = s_q;
    r_valid_d = r_valid_q;
    s_valid_d = s_valid_q;
    if (bus.flush_i) begin
      r_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (!r_valid_q || drain_s) begin
      if (s_valid_q) begin
        r_d       = s_q;
        r_valid_d = 1'b1;
        s_valid_d = 1'b0;
      end else if (accept_s) begin
        r_d       = dec_s;
        r_valid_d = 1'b1;
      end else begin
        r_valid_d = 1'b0;
      end
    end else if (accept_s) begin
      s_d       = dec_s;
      s_valid_d = 1'b1;
    end else begin
      s_valid_d = s_valid_q;
    end
  end

  // State registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_q       <= '0;
      s_q       <= '0;
      r_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
    end else begin
      r_q       <= r_d;
      s_q       <= s_d;
      r_valid_q <= r_valid_d;
      s_valid_q <= s_valid_d;
    end
  end

  assign bus.in_ready_o   = ~s_valid_q;
  assign bus.out_valid_o  = r_valid_q;
  assign bus.pc_o         = r_q.pc;
  assign bus.alu_op_o     = r_q.alu_op;
  assign bus.rs1_o        = r_q.rs1;
  assign bus.rs2_o        = r_q.rs2;
  assign bus.rd_o         = r_q.rd;
  assign bus.funct3_o     = r_q.funct3;
  assign bus.imm_o        = r_q.imm;
  assign bus.reg_write_o  = r_q.reg_write;
  assign bus.use_imm_o    = r_q.use_imm;
  assign bus.branch_o     = r_q.branch;
  assign bus.jump_o       = r_q.jump;
  assign bus.jalr_o       = r_q.jalr;
  assign bus.mem_read_o   = r_q.mem_read;
  assign bus.mem_write_o  = r_q.mem_write;
  assign bus.mem_to_reg_o = r_q.mem_to_reg;
  assign bus.lui_o        = r_q.lui;
  assign bus.auipc_o      = r_q.auipc;
  assign bus.system_o     = r_q.system;
  assign bus.illegal_o    = r_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed scoreboard bench for decode_stage: decode values, skid/stall, flush, reset.
module tb_decode_stage;
  localparam int XLEN = 32;
  localparam int PC_W = 32;

  localparam logic [10:0] F_RW   = 11'b10000000000;
  localparam logic [10:0] F_UI   = 11'b01000000000;
  localparam logic [10:0] F_BR   = 11'b00100000000;
  localparam logic [10:0] F_JMP  = 11'b00010000000;
  localparam logic [10:0] F_JALR = 11'b00001000000;
  localparam logic [10:0] F_MR   = 11'b00000100000;
  localparam logic [10:0] F_MW   = 11'b00000010000;
  localparam logic [10:0] F_M2R  = 11'b00000001000;
  localparam logic [10:0] F_LUI  = 11'b00000000100;
  localparam logic [10:0] F_AUI  = 11'b00000000010;
  localparam logic [10:0] F_SYS  = 11'b00000000001;
  localparam logic [10:0] F_NONE = 11'b00000000000;
`ifdef DECODE_ILLEGAL_EN
  localparam logic ILL_EXP = 1'b1;
`else
  localparam logic ILL_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  decode_stage_if #(.XLEN(XLEN), .PC_W(PC_W)) bus ();
  decode_stage #(.XLEN(XLEN), .PC_W(PC_W)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  always #5 clk = ~clk;

  logic [97:0] act_s;
  assign act_s = {bus.pc_o, bus.alu_op_o, bus.rs1_o, bus.rs2_o, bus.rd_o, bus.funct3_o,
                  bus.imm_o, bus.reg_write_o, bus.use_imm_o, bus.branch_o, bus.jump_o,
                  bus.jalr_o, bus.mem_read_o, bus.mem_write_o, bus.mem_to_reg_o,
                  bus.lui_o, bus.auipc_o, bus.system_o, bus.illegal_o};

  logic [97:0] exp_q[$];
  string       tag_q[$];
  logic [97:0] exp_in;
  string       cur_tag;
  int          total = 0;
  int          bad = 0;
  bit          accepted;

  task automatic check(input string tag, input logic [97:0] obs, input logic [97:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock: score at the falling edge, return 1 time unit after the rising edge.
  task automatic cycle();
    logic [97:0] e;
    string t;
    @(negedge clk);
    accepted = 1'b0;
    if (bus.flush_i) begin
      exp_q.delete();
      tag_q.delete();
    end else begin
      if (bus.out_valid_o && bus.out_ready_i) begin
        total++;
        assert (exp_q.size() != 0) else begin
          bad++;
          $error("FAIL spurious_out observed=%h expected=none", act_s);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          t = tag_q.pop_front();
          check(t, act_s, e);
        end
      end
      if (bus.in_valid_i && bus.in_ready_o) begin
        exp_q.push_back(exp_in);
        tag_q.push_back(cur_tag);
        accepted = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic present(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                         input logic [3:0] alu, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [31:0] imm, input logic [10:0] fl,
                         input logic ill);
    bus.in_valid_i = 1'b1;
    bus.instr_i    = ins;
    bus.pc_i       = pc;
    cur_tag        = tag;
    exp_in         = {pc, alu, rs1, rs2, rd, ins[14:12], imm, fl, ill};
  endtask

  task automatic wait_accept();
    int n = 0;
    do begin
      cycle();
      n++;
    end while (!accepted && n < 20);
    total++;
    assert (accepted) else begin
      bad++;
      $error("FAIL accept_timeout %s observed=0 expected=1", cur_tag);
    end
  endtask

  task automatic send(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                      input logic [3:0] alu, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic [31:0] imm, input logic [10:0] fl,
                      input logic ill);
    present(tag, ins, pc, alu, rs1, rs2, rd, imm, fl, ill);
    wait_accept();
  endtask

  initial begin
    rst = 1'b1;
    bus.flush_i = 1'b0;
    bus.in_valid_i = 1'b0;
    bus.instr_i = 32'h0;
    bus.pc_i = 32'h0;
    bus.out_ready_i = 1'b0;
    exp_in = '0;
    cur_tag = "none";
    accepted = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 98'(bus.out_valid_o), 98'(1'b0));
    check("reset_in_ready", 98'(bus.in_ready_o), 98'(1'b1));
    check("reset_bundle", act_s, 98'(0));
    rst = 1'b0;
    cycle();
    check("idle_out_valid", 98'(bus.out_valid_o), 98'(1'b0));

    // Back-to-back stream with execute always ready
    bus.out_ready_i = 1'b1;
    send("addi",   32'hFFF00093, 32'h1000, 4'b0000, 5'd0, 5'd0, 5'd1, 32'hFFFFFFFF, F_RW | F_UI, 1'b0);
    send("srai",   32'h40315113, 32'h1004, 4'b1000, 5'd2, 5'd0, 5'd2, 32'h00000403, F_RW | F_UI, 1'b0);
    send("sub",    32'h40208033, 32'h1008, 4'b0111, 5'd1, 5'd2, 5'd0, 32'h0, F_RW, 1'b0);
    send("beq",    32'hFE000EE3, 32'h100C, 4'b0001, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, F_BR, 1'b0);
    send("jalr",   32'h000080E7, 32'h1010, 4'b0000, 5'd1, 5'd0, 5'd1, 32'h0, F_RW | F_UI | F_JMP | F_JALR, 1'b0);
    send("lui",    32'h123452B7, 32'h1014, 4'b0000, 5'd0, 5'd0, 5'd5, 32'h12345000, F_RW | F_UI | F_LUI, 1'b0);
    send("auipc",  32'hFFFFF217, 32'h1018, 4'b0000, 5'd0, 5'd0, 5'd4, 32'hFFFFF000, F_RW | F_UI | F_AUI, 1'b0);
    send("lw",     32'h0080A183, 32'h101C, 4'b0000, 5'd1, 5'd0, 5'd3, 32'h8, F_RW | F_UI | F_MR | F_M2R, 1'b0);
    send("sw",     32'h0020A623, 32'h1020, 4'b0000, 5'd1, 5'd2, 5'd0, 32'hC, F_UI | F_MW, 1'b0);
    send("jal",    32'hFF9FF0EF, 32'h1024, 4'b0000, 5'd0, 5'd0, 5'd1, 32'hFFFFFFF8, F_RW | F_UI | F_JMP, 1'b0);
    send("or",     32'h0062E3B3, 32'h1028, 4'b0011, 5'd5, 5'd6, 5'd7, 32'h0, F_RW, 1'b0);
    send("bgeu",   32'h0020F463, 32'h102C, 4'b0110, 5'd1, 5'd2, 5'd0, 32'h8, F_BR, 1'b0);
    send("fence",  32'h0FF0000F, 32'h1030, 4'b0000, 5'd0, 5'd0, 5'd0, 32'h0, F_NONE, 1'b0);
    send("ecall",  32'h00000073, 32'h1034, 4'b0000, 5'd0, 5'd0, 5'd0, 32'h0, F_SYS, 1'b0);
    send("ebreak", 32'h00100073, 32'h1038, 4'b0000, 5'd0, 5'd0, 5'd0, 32'h0, F_SYS, 1'b0);
    send("zero",   32'h00000000, 32'h103C, 4'b0000, 5'd0, 5'd0, 5'd0, 32'h0, F_NONE, ILL_EXP);
    bus.in_valid_i = 1'b0;
    repeat (2) cycle();

    // Stall: first in R, second in S, third held off
    bus.out_ready_i = 1'b0;
    send("stall_a", 32'hFFF00093, 32'h2000, 4'b0000, 5'd0, 5'd0, 5'd1, 32'hFFFFFFFF, F_RW | F_UI, 1'b0);
    send("stall_b", 32'h40208033, 32'h2004, 4'b0111, 5'd1, 5'd2, 5'd0, 32'h0, F_RW, 1'b0);
    present("stall_c", 32'hFE000EE3, 32'h2008, 4'b0001, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, F_BR, 1'b0);
    check("stall_in_ready", 98'(bus.in_ready_o), 98'(1'b0));
    check("stall_out_valid", 98'(bus.out_valid_o), 98'(1'b1));
    cycle();
    check("stall_hold_pc", 98'(bus.pc_o), 98'(32'h2000));
    check("stall_hold_imm", 98'(bus.imm_o), 98'(32'hFFFFFFFF));
    check("stall_c_blocked", 98'(accepted), 98'(1'b0));
    bus.out_ready_i = 1'b1;
    wait_accept();
    bus.in_valid_i = 1'b0;
    repeat (3) cycle();
    check("stall_drained", 98'(exp_q.size()), 98'(0));

    // Flush with R and S both full and a new instruction offered
    bus.out_ready_i = 1'b0;
    send("fl_a", 32'h0062E3B3, 32'h3000, 4'b0011, 5'd5, 5'd6, 5'd7, 32'h0, F_RW, 1'b0);
    send("fl_b", 32'h0020A623, 32'h3004, 4'b0000, 5'd1, 5'd2, 5'd0, 32'hC, F_UI | F_MW, 1'b0);
    present("fl_c", 32'h40315113, 32'h3008, 4'b1000, 5'd2, 5'd0, 5'd2, 32'h00000403, F_RW | F_UI, 1'b0);
    bus.flush_i = 1'b1;
    cycle();
    bus.flush_i = 1'b0;
    bus.in_valid_i = 1'b0;
    check("flush_out_valid", 98'(bus.out_valid_o), 98'(1'b0));
    check("flush_in_ready", 98'(bus.in_ready_o), 98'(1'b1));
    bus.out_ready_i = 1'b1;
    repeat (3) cycle();

    // Flush with only R full: an acceptable input in the flush cycle is dropped
    bus.out_ready_i = 1'b0;
    send("fl_d", 32'h000080E7, 32'h3010, 4'b0000, 5'd1, 5'd0, 5'd1, 32'h0, F_RW | F_UI | F_JMP | F_JALR, 1'b0);
    present("fl_e", 32'h123452B7, 32'h3014, 4'b0000, 5'd0, 5'd0, 5'd5, 32'h12345000, F_RW | F_UI | F_LUI, 1'b0);
    bus.flush_i = 1'b1;
    cycle();
    bus.flush_i = 1'b0;
    bus.in_valid_i = 1'b0;
    bus.out_ready_i = 1'b1;
    check("flush2_out_valid", 98'(bus.out_valid_o), 98'(1'b0));
    repeat (2) cycle();
    send("post_flush", 32'h0020F463, 32'h3018, 4'b0110, 5'd1, 5'd2, 5'd0, 32'h8, F_BR, 1'b0);
    bus.in_valid_i = 1'b0;
    repeat (2) cycle();

    // Asynchronous reset in mid-operation discards held bundles at once
    bus.out_ready_i = 1'b0;
    send("rst_a", 32'hFFF00093, 32'h4000, 4'b0000, 5'd0, 5'd0, 5'd1, 32'hFFFFFFFF, F_RW | F_UI, 1'b0);
    send("rst_b", 32'h40208033, 32'h4004, 4'b0111, 5'd1, 5'd2, 5'd0, 32'h0, F_RW, 1'b0);
    bus.in_valid_i = 1'b0;
    rst = 1'b1;
    #2;
    check("async_rst_out_valid", 98'(bus.out_valid_o), 98'(1'b0));
    check("async_rst_in_ready", 98'(bus.in_ready_o), 98'(1'b1));
    exp_q.delete();
    tag_q.delete();
    cycle();
    rst = 1'b0;
    bus.out_ready_i = 1'b1;
    repeat (3) cycle();

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle();
    check("final_queue_empty", 98'(exp_q.size()), 98'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
